// File: rtl/imuldiv_mul_arbiter.sv
// imuldiv_mul_arbiter: round-robin sharing of one iterative multiplier between two val/rdy requesters
module imuldiv_mul_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   req0_msg_a,
  input  logic [WIDTH-1:0]   req0_msg_b,
  input  logic               req0_val,
  output logic               req0_rdy,
  output logic [2*WIDTH-1:0] resp0_msg,
  output logic               resp0_val,
  input  logic               resp0_rdy,
  input  logic [WIDTH-1:0]   req1_msg_a,
  input  logic [WIDTH-1:0]   req1_msg_b,
  input  logic               req1_val,
  output logic               req1_rdy,
  output logic [2*WIDTH-1:0] resp1_msg,
  output logic               resp1_val,
  input  logic               resp1_rdy,
  output logic [WIDTH-1:0]   mul_req_msg_a,
  output logic [WIDTH-1:0]   mul_req_msg_b,
  output logic               mul_req_val,
  input  logic               mul_req_rdy,
  input  logic [2*WIDTH-1:0] mul_resp_msg,
  input  logic               mul_resp_val,
  output logic               mul_resp_rdy,
  output logic               busy,
  output logic               owner
);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state;
  logic prio, win, grant, done;
  logic [WIDTH-1:0] op_a, op_b;
  // rdy is gated by reset so no request is accepted while reset is held
  always_comb begin
    win = (req0_val & req1_val) ? prio : req1_val;
    grant = (state == IDLE) & (req0_val | req1_val);
    req0_rdy = reset & grant & ~win;
    req1_rdy = reset & grant & win;
    mul_req_val = state == SEND;
    mul_req_msg_a = op_a;
    mul_req_msg_b = op_b;
    resp0_val = (state == WAIT) & ~owner & mul_resp_val;
    resp1_val = (state == WAIT) & owner & mul_resp_val;
    resp0_msg = resp0_val ? mul_resp_msg : '0;
    resp1_msg = resp1_val ? mul_resp_msg : '0;
    mul_resp_rdy = (state == WAIT) & (owner ? resp1_rdy : resp0_rdy);
    done = mul_resp_val & mul_resp_rdy;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      prio <= 1'b0;
      owner <= 1'b0;
      op_a <= '0;
      op_b <= '0;
    end else
      case (state)
        IDLE: if (grant) begin
          state <= SEND;
          owner <= win;
          op_a <= win ? req1_msg_a : req0_msg_a;
          op_b <= win ? req1_msg_b : req0_msg_b;
        end
        SEND: if (mul_req_rdy) state <= WAIT;
        WAIT: if (done) begin
          state <= IDLE;
          prio <= ~owner;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// tb_imuldiv_mul_arbiter: directed and random checks against a transaction-level arbiter and multiplier model
module tb_imuldiv_mul_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b, mul_req_msg_a, mul_req_msg_b;
  logic req0_val, req0_rdy, resp0_val, resp0_rdy, req1_val, req1_rdy, resp1_val, resp1_rdy;
  logic [7:0] resp0_msg, resp1_msg, mul_resp_msg;
  logic mul_req_val, mul_req_rdy, mul_resp_val, mul_resp_rdy, busy, owner;
  int n_assert, n_fail;
  logic out, sent, mown, mprio, mpend, mrdy_en, mrand, rr_rand;
  logic [3:0] ea, eb;
  logic [7:0] mprod;
  int mcnt, mlat, mode0, mode1;
  logic grants[$];
  logic [8:0] resps[$];

  always #5 clk = ~clk;

  imuldiv_mul_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
    .resp0_msg(resp0_msg), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp1_msg(resp1_msg), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .mul_req_msg_a(mul_req_msg_a), .mul_req_msg_b(mul_req_msg_b), .mul_req_val(mul_req_val),
    .mul_req_rdy(mul_req_rdy), .mul_resp_msg(mul_resp_msg), .mul_resp_val(mul_resp_val),
    .mul_resp_rdy(mul_resp_rdy), .busy(busy), .owner(owner)
  );

  function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
    int x;
    x = $signed(a) * $signed(b);
    return x[7:0];
  endfunction

  function automatic logic [8:0] got(input int i);
    return resps.size() > i ? resps[i] : 9'h1FF;
  endfunction

  function automatic logic gr(input int i);
    return grants.size() > i ? grants[i] : 1'bx;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    out = 1'b0; sent = 1'b0; mprio = 1'b0; mpend = 1'b0; mcnt = 0;
    mul_resp_val = 1'b0;
    mul_req_rdy = mrdy_en;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
  endtask

  // one clock: check DUT against the model at negedge, advance model, drive next inputs
  task automatic tick();
    logic f0, f1, fm, fr, frm, w, e0, e1;
    logic [3:0] ma, mb;
    @(negedge clk);
    w = out & sent;
    e0 = !out & req0_val & (!req1_val | !mprio);
    e1 = !out & req1_val & (!req0_val | mprio);
    chk("req_rdy", 16'({req0_rdy, req1_rdy}), 16'({e0, e1}));
    chk("mul_req_val", 16'(mul_req_val), 16'(out & !sent));
    if (out & !sent) chk("mul_req_msg", 16'({mul_req_msg_a, mul_req_msg_b}), 16'({ea, eb}));
    chk("mul_resp_rdy", 16'(mul_resp_rdy), 16'(w & (mown ? resp1_rdy : resp0_rdy)));
    e0 = w & !mown & mul_resp_val;
    e1 = w & mown & mul_resp_val;
    chk("resp_val", 16'({resp0_val, resp1_val}), 16'({e0, e1}));
    chk("resp0_msg", 16'(resp0_msg), 16'(e0 ? prod(ea, eb) : 8'h0));
    chk("resp1_msg", 16'(resp1_msg), 16'(e1 ? prod(ea, eb) : 8'h0));
    chk("busy", 16'(busy), 16'(out));
    if (out) chk("owner", 16'(owner), 16'(mown));
    f0 = req0_val & req0_rdy;
    f1 = req1_val & req1_rdy;
    fm = mul_req_val & mul_req_rdy;
    fr = mul_resp_val & mul_resp_rdy;
    frm = w & mul_resp_val & (mown ? resp1_rdy : resp0_rdy);
    ma = mul_req_msg_a;
    mb = mul_req_msg_b;
    if (resp0_val & resp0_rdy) resps.push_back({1'b0, resp0_msg});
    if (resp1_val & resp1_rdy) resps.push_back({1'b1, resp1_msg});
    if (f0 | f1) begin
      grants.push_back(f1);
      mown = f1;
      ea = f1 ? req1_msg_a : req0_msg_a;
      eb = f1 ? req1_msg_b : req0_msg_b;
      out = 1'b1;
      sent = 1'b0;
    end
    if (fm) sent = 1'b1;
    if (frm) begin
      out = 1'b0;
      mprio = !mown;
    end
    @(posedge clk);
    #1;
    if (fm) begin
      mpend = 1'b1;
      mprod = prod(ma, mb);
      mcnt = mrand ? int'($urandom_range(0, 3)) : mlat;
    end else if (fr) mpend = 1'b0;
    else if (mpend && mcnt > 0) mcnt--;
    if (mrand) mrdy_en = 1'($urandom_range(0, 1));
    mul_req_rdy = !mpend & mrdy_en;
    mul_resp_val = mpend ? (mcnt == 0) : (mrand & 1'($urandom_range(0, 1)));
    mul_resp_msg = (mpend && mcnt == 0) ? mprod : 8'($urandom);
    if (f0) req0_val = 1'b0;
    if (mode0 != 0 && !req0_val) begin
      req0_val = mode0 == 1 ? 1'b1 : 1'($urandom_range(0, 1));
      req0_msg_a = 4'($urandom);
      req0_msg_b = 4'($urandom);
    end
    if (f1) req1_val = 1'b0;
    if (mode1 != 0 && !req1_val) begin
      req1_val = mode1 == 1 ? 1'b1 : 1'($urandom_range(0, 1));
      req1_msg_a = 4'($urandom);
      req1_msg_b = 4'($urandom);
    end
    if (rr_rand) begin
      resp0_rdy = 1'($urandom_range(0, 1));
      resp1_rdy = 1'($urandom_range(0, 1));
    end
    #1;
  endtask

  task automatic run_until(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && resps.size() < n; i++) tick();
    chk(tag, 16'(resps.size() >= n), 16'h1);
  endtask

  task automatic clear();
    grants.delete();
    resps.delete();
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    mode0 = 0; mode1 = 0; mrdy_en = 1'b1; mrand = 1'b0; rr_rand = 1'b0; mlat = 2;
    mown = 1'b0; ea = 4'h0; eb = 4'h0; mprod = 8'h0;
    req0_msg_a = 4'h0; req0_msg_b = 4'h0; req1_msg_a = 4'h0; req1_msg_b = 4'h0;
    req0_val = 1'b1; req1_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    mul_resp_msg = 8'h0; mul_req_rdy = 1'b1; mul_resp_val = 1'b0;
    reset = 1'b1;
    #1;
    hold_reset();
    #3;
    chk("reset_ctl", 16'({req0_rdy, req1_rdy, mul_req_val, mul_resp_rdy, resp0_val, resp1_val, busy, owner}), 16'h0);
    chk("reset_msg", {resp0_msg, resp1_msg}, 16'h0);
    req0_val = 1'b0; req1_val = 1'b0;
    release_reset();
    // single request on port 0
    req0_msg_a = 4'h3; req0_msg_b = 4'h5; req0_val = 1'b1;
    clear();
    run_until(1, 20, "t1_done");
    chk("t1_resp", 16'(got(0)), 16'({1'b0, 8'h0F}));
    // both ports valid on the first cycle after reset
    hold_reset();
    req0_msg_a = 4'h2; req0_msg_b = 4'h3; req0_val = 1'b1;
    req1_msg_a = 4'hE; req1_msg_b = 4'h3; req1_val = 1'b1;
    clear();
    release_reset();
    run_until(2, 30, "t2_done");
    chk("t2_first", 16'(got(0)), 16'({1'b0, 8'h06}));
    chk("t2_second", 16'(got(1)), 16'({1'b1, 8'hFA}));
    // both continuously valid: grants alternate
    mode0 = 1; mode1 = 1;
    clear();
    run_until(4, 60, "t3_done");
    chk("t3_order", 16'({gr(0), gr(1), gr(2), gr(3)}), 16'h5);
    // response backpressure on port 1
    mode0 = 0; mode1 = 0; req0_val = 1'b0;
    req1_msg_a = 4'h9; req1_msg_b = 4'h6; req1_val = 1'b1;
    resp1_rdy = 1'b0; mlat = 1;
    clear();
    for (int i = 0; i < 20 && !resp1_val; i++) tick();
    chk("t4_reach", 16'(resp1_val), 16'h1);
    repeat (3) begin
      tick();
      chk("t4_mul_resp_rdy", 16'(mul_resp_rdy), 16'h0);
      chk("t4_msg", 16'(resp1_msg), 16'hD6);
      chk("t4_busy", 16'(busy), 16'h1);
    end
    resp1_rdy = 1'b1;
    run_until(1, 10, "t4_done");
    chk("t4_resp", 16'(got(0)), 16'({1'b1, 8'hD6}));
    // slow multiplier: request held, no new grants
    mrdy_en = 1'b0;
    req0_msg_a = 4'h7; req0_msg_b = 4'hF; req0_val = 1'b1;
    req1_msg_a = 4'h2; req1_msg_b = 4'h2; req1_val = 1'b1;
    clear();
    for (int i = 0; i < 20 && !mul_req_val; i++) tick();
    chk("t5_reach", 16'(mul_req_val), 16'h1);
    repeat (5) begin
      tick();
      chk("t5_val", 16'(mul_req_val), 16'h1);
      chk("t5_ops", 16'({mul_req_msg_a, mul_req_msg_b}), 16'h7F);
      chk("t5_rdys", 16'({req0_rdy, req1_rdy}), 16'h0);
    end
    mrdy_en = 1'b1;
    run_until(2, 40, "t5_done");
    chk("t5_first", 16'(got(0)), 16'({1'b0, 8'hF9}));
    chk("t5_second", 16'(got(1)), 16'({1'b1, 8'h04}));
    // reset in the middle of a port-1 WAIT, after port 0 completed
    mlat = 3;
    req0_msg_a = 4'h1; req0_msg_b = 4'h1; req0_val = 1'b1;
    req1_msg_a = 4'h2; req1_msg_b = 4'h2; req1_val = 1'b1;
    clear();
    run_until(1, 20, "t6_first");
    for (int i = 0; i < 20 && !(busy && owner && !mul_req_val); i++) tick();
    chk("t6_reach", 16'({busy, owner, mul_req_val}), 16'h6);
    req0_msg_a = 4'h5; req0_msg_b = 4'h5; req0_val = 1'b1;
    req1_msg_a = 4'h3; req1_msg_b = 4'h3; req1_val = 1'b1;
    hold_reset();
    chk("t6_ctl", 16'({req0_rdy, req1_rdy, resp0_val, resp1_val, mul_req_val, mul_resp_rdy, busy, owner}), 16'h0);
    clear();
    release_reset();
    run_until(1, 20, "t6_done");
    chk("t6_grant", 16'(gr(0)), 16'h0);
    chk("t6_resp", 16'(got(0)), 16'({1'b0, 8'h19}));
    // random traffic, random backpressure, random multiplier latency and stray results
    mode0 = 2; mode1 = 2; rr_rand = 1'b1; mrand = 1'b1;
    clear();
    repeat (500) tick();
    mode0 = 0; mode1 = 0; rr_rand = 1'b0; mrand = 1'b0; mrdy_en = 1'b1;
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    for (int i = 0; i < 60 && (busy || req0_val || req1_val); i++) tick();
    chk("drain", 16'({busy, req0_val, req1_val}), 16'h0);
    chk("rand_activity", 16'(resps.size() > 20), 16'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
